// File: rtl/memory_pkg.sv
// Shared types for the memory game engine and the video generator.
package memory_pkg;

    typedef enum logic [1:0] {
        HIDDEN  = 2'b00,
        SHOWN   = 2'b01,
        MATCHED = 2'b10
    } card_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK1,
        S_PICK2,
        S_CMP,
        S_REVEAL,
        S_OVER
    } game_state_t;

    // Width of the seconds / reveal counters (turn timeout is at most 255).
    localparam int TIMER_W = 8;

    // Player index width; a 2-player game still needs one bit.
    function automatic int pl_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/memory_turn_engine_if.sv
// Control inputs and board/score outputs of the play engine.
interface memory_turn_engine_if
    import memory_pkg::*;
#(
    parameter int NUM_CARDS   = 16,
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 4
);
    localparam int IDX_W = $clog2(NUM_CARDS);
    localparam int SYM_W = $clog2(NUM_CARDS / 2);
    localparam int PL_W  = pl_width(NUM_PLAYERS);

    logic                           start;
    logic [NUM_CARDS*SYM_W-1:0]     deck_sym;
    logic                           tick;
    logic                           left;
    logic                           right;
    logic                           sel;
    logic [NUM_CARDS*2-1:0]         card_st;
    logic [NUM_CARDS*SYM_W-1:0]     card_sym;
    logic [IDX_W-1:0]               cursor;
    logic [PL_W-1:0]                turn;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores;
    logic [TIMER_W-1:0]             secs_left;
    logic                           game_over;
    logic [PL_W:0]                  winner;

    modport master (
        output start, deck_sym, tick, left, right, sel,
        input  card_st, card_sym, cursor, turn, scores, secs_left, game_over, winner
    );

    modport slave (
        input  start, deck_sym, tick, left, right, sel,
        output card_st, card_sym, cursor, turn, scores, secs_left, game_over, winner
    );

endinterface

// File: rtl/turn_timer.sv
// Loadable down-counter used for the turn timeout and the mismatch reveal delay.
// expire flags the enabled step that takes the count from 1 to 0.
module turn_timer #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         expire
);
    logic [W-1:0] count_q, count_d;

    // Next count: load has priority over counting, counter parks at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign expire = en && (count_q == W'(1));

endmodule

// File: rtl/memory_turn_engine.sv
// Play engine for the memory card game: board state, cursor, turns, scores, timers.
module memory_turn_engine
    import memory_pkg::*;
#(
    parameter int NUM_CARDS    = 16,
    parameter int NUM_PLAYERS  = 2,
    parameter int SCORE_W      = 4,
    parameter int TURN_SECS    = 15,
    parameter int REVEAL_TICKS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    memory_turn_engine_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_CARDS);
    localparam int SYM_W = $clog2(NUM_CARDS / 2);
    localparam int PL_W  = pl_width(NUM_PLAYERS);

    localparam logic [TIMER_W-1:0] TURN_LD   = TIMER_W'(TURN_SECS);
    localparam logic [TIMER_W-1:0] REVEAL_LD = TIMER_W'(REVEAL_TICKS);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [IDX_W-1:0]   PAIRS     = IDX_W'(NUM_CARDS / 2);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_CARDS - 1);
    localparam logic [PL_W-1:0]    LAST_PL   = PL_W'(NUM_PLAYERS - 1);

    game_state_t        state_q, state_d;
    card_state_t        st_q    [NUM_CARDS];
    card_state_t        st_d    [NUM_CARDS];
    logic [SYM_W-1:0]   sym_q   [NUM_CARDS];
    logic [SYM_W-1:0]   sym_d   [NUM_CARDS];
    logic [SCORE_W-1:0] score_q [NUM_PLAYERS];
    logic [SCORE_W-1:0] score_d [NUM_PLAYERS];
    logic [IDX_W-1:0]   cursor_q, cursor_d;
    logic [IDX_W-1:0]   a_q, a_d, b_q, b_d;
    logic [IDX_W-1:0]   matched_q, matched_d;
    logic [PL_W-1:0]    turn_q, turn_d;
    logic               game_over_q, game_over_d;
    logic [PL_W:0]      winner_q, winner_d;

    logic               tmr_load, tmr_en, tmr_expire;
    logic               rev_load, rev_en, rev_expire;
    logic [TIMER_W-1:0] tmr_count, rev_count;
    logic [PL_W-1:0]    next_turn;
    logic               in_pick, mv_right, mv_left, to_over, tie;
    logic [SCORE_W-1:0] best;
    logic [PL_W-1:0]    best_pl;
    logic [PL_W:0]      win_calc;

    assign in_pick   = (state_q == S_PICK1) || (state_q == S_PICK2);
    assign mv_right  = bus.right && !bus.left;
    assign mv_left   = bus.left && !bus.right;
    assign next_turn = (turn_q == LAST_PL) ? '0 : turn_q + 1'b1;
    assign tmr_en    = bus.tick && in_pick;
    assign rev_en    = bus.tick && (state_q == S_REVEAL);

    turn_timer #(.W(TIMER_W), .RST_VAL(TURN_LD)) u_turn_tmr (
        .clk(clk), .rst(rst), .load(tmr_load), .load_val(TURN_LD),
        .en(tmr_en), .count(tmr_count), .expire(tmr_expire)
    );

    turn_timer #(.W(TIMER_W), .RST_VAL('0)) u_reveal_tmr (
        .clk(clk), .rst(rst), .load(rev_load), .load_val(REVEAL_LD),
        .en(rev_en), .count(rev_count), .expire(rev_expire)
    );

    // Game sequencing: next board, cursor, turn, score and winner values.
    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        sym_d       = sym_q;
        score_d     = score_q;
        cursor_d    = cursor_q;
        a_d         = a_q;
        b_d         = b_q;
        matched_d   = matched_q;
        turn_d      = turn_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        tmr_load    = 1'b0;
        rev_load    = 1'b0;
        to_over     = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    for (int i = 0; i < NUM_CARDS; i++) begin
                        st_d[i]  = HIDDEN;
                        sym_d[i] = bus.deck_sym[i*SYM_W +: SYM_W];
                    end
                    for (int p = 0; p < NUM_PLAYERS; p++) score_d[p] = '0;
                    turn_d      = '0;
                    cursor_d    = '0;
                    matched_d   = '0;
                    winner_d    = '0;
                    game_over_d = 1'b0;
                    tmr_load    = 1'b1;
                    state_d     = S_PICK1;
                end
            end
            S_PICK1, S_PICK2: begin
                if (mv_right) begin
                    cursor_d = (cursor_q == LAST_IDX) ? '0 : cursor_q + 1'b1;
                end else if (mv_left) begin
                    cursor_d = (cursor_q == '0) ? LAST_IDX : cursor_q - 1'b1;
                end
                // A timeout tick beats a simultaneous pick.
                if (tmr_expire) begin
                    if (state_q == S_PICK2) st_d[a_q] = HIDDEN;
                    turn_d   = next_turn;
                    tmr_load = 1'b1;
                    state_d  = S_PICK1;
                end else if (bus.sel && (st_q[cursor_q] == HIDDEN)) begin
                    // Card a is SHOWN in S_PICK2, so it can never be picked twice.
                    st_d[cursor_q] = SHOWN;
                    if (state_q == S_PICK1) begin
                        a_d     = cursor_q;
                        state_d = S_PICK2;
                    end else begin
                        b_d     = cursor_q;
                        state_d = S_CMP;
                    end
                end
            end
            S_CMP: begin
                if (sym_q[a_q] == sym_q[b_q]) begin
                    st_d[a_q] = MATCHED;
                    st_d[b_q] = MATCHED;
                    if (score_q[turn_q] != SCORE_MAX) score_d[turn_q] = score_q[turn_q] + 1'b1;
                    matched_d = matched_q + 1'b1;
                    tmr_load  = 1'b1;
                    if (matched_d == PAIRS) begin
                        to_over     = 1'b1;
                        game_over_d = 1'b1;
                        state_d     = S_OVER;
                    end else begin
                        state_d = S_PICK1;
                    end
                end else begin
                    rev_load = 1'b1;
                    state_d  = S_REVEAL;
                end
            end
            S_REVEAL: begin
                if (rev_expire) begin
                    st_d[a_q] = HIDDEN;
                    st_d[b_q] = HIDDEN;
                    turn_d    = next_turn;
                    tmr_load  = 1'b1;
                    state_d   = S_PICK1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Winner over the updated scores; any repeat of the maximum is a tie.
        best    = score_d[0];
        best_pl = '0;
        tie     = 1'b0;
        for (int p = 1; p < NUM_PLAYERS; p++) begin
            if (score_d[p] > best) begin
                best    = score_d[p];
                best_pl = PL_W'(p);
                tie     = 1'b0;
            end else if (score_d[p] == best) begin
                tie = 1'b1;
            end
        end
        win_calc = tie ? {1'b1, {PL_W{1'b0}}} : {1'b0, best_pl};
        if (to_over) winner_d = win_calc;
    end

    // Engine state registers; reset aborts any game in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < NUM_CARDS; i++) begin
                st_q[i]  <= HIDDEN;
                sym_q[i] <= '0;
            end
            for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
            cursor_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            matched_q   <= '0;
            turn_q      <= '0;
            game_over_q <= 1'b0;
            winner_q    <= '0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            sym_q       <= sym_d;
            score_q     <= score_d;
            cursor_q    <= cursor_d;
            a_q         <= a_d;
            b_q         <= b_d;
            matched_q   <= matched_d;
            turn_q      <= turn_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    for (genvar i = 0; i < NUM_CARDS; i++) begin : g_cards
        assign bus.card_st[i*2 +: 2]          = st_q[i];
        assign bus.card_sym[i*SYM_W +: SYM_W] = sym_q[i];
    end
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_scores
        assign bus.scores[p*SCORE_W +: SCORE_W] = score_q[p];
    end

    assign bus.cursor    = cursor_q;
    assign bus.turn      = turn_q;
    assign bus.secs_left = tmr_count;
    assign bus.game_over = game_over_q;
    assign bus.winner    = winner_q;

endmodule

// File: tb/tb_memory_turn_engine.sv
// Directed bench for memory_turn_engine: 16 cards, 3 players, 2-bit scores.
module tb_memory_turn_engine;
    localparam int NC   = 16;
    localparam int NP   = 3;
    localparam int SW   = 2;
    localparam int TS   = 15;
    localparam int RT   = 2;
    localparam int SYMW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    memory_turn_engine_if #(.NUM_CARDS(NC), .NUM_PLAYERS(NP), .SCORE_W(SW)) bus ();

    memory_turn_engine #(
        .NUM_CARDS(NC), .NUM_PLAYERS(NP), .SCORE_W(SW),
        .TURN_SECS(TS), .REVEAL_TICKS(RT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Game model: phase 0 idle, 1 first pick, 2 second pick, 3 compare, 4 reveal, 5 over.
    int m_ph, m_cur, m_trn, m_secs, m_rev, m_a, m_b, m_nm, m_go, m_win;
    int m_st [NC];
    int m_sym[NC];
    int m_sc [NP];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ph = 0; m_cur = 0; m_trn = 0; m_secs = TS; m_rev = 0;
        m_a = 0; m_b = 0; m_nm = 0; m_go = 0; m_win = 0;
        for (int i = 0; i < NC; i++) begin m_st[i] = 0; m_sym[i] = 0; end
        for (int p = 0; p < NP; p++) m_sc[p] = 0;
    endtask

    function automatic int m_winner();
        int mx = -1;
        int who = 0;
        int cnt = 0;
        for (int p = 0; p < NP; p++) if (m_sc[p] > mx) begin mx = m_sc[p]; who = p; end
        for (int p = 0; p < NP; p++) if (m_sc[p] == mx) cnt++;
        return (cnt > 1) ? 4 : who;
    endfunction

    task automatic m_step();
        int nxt;
        nxt = m_cur;
        case (m_ph)
            0, 5: if (bus.start) begin
                for (int i = 0; i < NC; i++) begin
                    m_st[i]  = 0;
                    m_sym[i] = int'(bus.deck_sym[i*SYMW +: SYMW]);
                end
                for (int p = 0; p < NP; p++) m_sc[p] = 0;
                m_trn = 0; m_cur = 0; m_nm = 0; m_win = 0; m_go = 0; m_secs = TS; m_ph = 1;
            end
            1, 2: begin
                if (bus.right && !bus.left) nxt = (m_cur + 1) % NC;
                if (bus.left && !bus.right) nxt = (m_cur + NC - 1) % NC;
                if (bus.tick && m_secs == 1) begin
                    if (m_ph == 2) m_st[m_a] = 0;
                    m_trn = (m_trn + 1) % NP; m_secs = TS; m_ph = 1;
                end else begin
                    if (bus.tick) m_secs--;
                    if (bus.sel && m_st[m_cur] == 0) begin
                        m_st[m_cur] = 1;
                        if (m_ph == 1) begin m_a = m_cur; m_ph = 2; end
                        else begin m_b = m_cur; m_ph = 3; end
                    end
                end
                m_cur = nxt;
            end
            3: if (m_sym[m_a] == m_sym[m_b]) begin
                m_st[m_a] = 2; m_st[m_b] = 2;
                if (m_sc[m_trn] < (1 << SW) - 1) m_sc[m_trn]++;
                m_nm++; m_secs = TS;
                if (m_nm == NC / 2) begin m_ph = 5; m_go = 1; m_win = m_winner(); end
                else m_ph = 1;
            end else begin
                m_rev = RT; m_ph = 4;
            end
            4: if (bus.tick) begin
                m_rev--;
                if (m_rev == 0) begin
                    m_st[m_a] = 0; m_st[m_b] = 0;
                    m_trn = (m_trn + 1) % NP; m_secs = TS; m_ph = 1;
                end
            end
            default: m_ph = 0;
        endcase
    endtask

    task automatic m_compare();
        logic [2*NC-1:0]    es;
        logic [SYMW*NC-1:0] ey;
        logic [SW*NP-1:0]   esc;
        for (int i = 0; i < NC; i++) begin
            es[i*2 +: 2]       = m_st[i][1:0];
            ey[i*SYMW +: SYMW] = m_sym[i][SYMW-1:0];
        end
        for (int p = 0; p < NP; p++) esc[p*SW +: SW] = m_sc[p][SW-1:0];
        chk("card_st",   64'(bus.card_st),   64'(es));
        chk("card_sym",  64'(bus.card_sym),  64'(ey));
        chk("cursor",    64'(bus.cursor),    64'(m_cur));
        chk("turn",      64'(bus.turn),      64'(m_trn));
        chk("scores",    64'(bus.scores),    64'(esc));
        chk("secs_left", 64'(bus.secs_left), 64'(m_secs));
        chk("game_over", 64'(bus.game_over), 64'(m_go));
        chk("winner",    64'(bus.winner),    64'(m_win));
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            m_compare();
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse(input bit s, input bit l, input bit r, input bit t, input bit st);
        @(negedge clk);
        bus.sel = s; bus.left = l; bus.right = r; bus.tick = t; bus.start = st;
        @(negedge clk);
        bus.sel = 0; bus.left = 0; bus.right = 0; bus.tick = 0; bus.start = 0;
    endtask

    task automatic goto(input int t);
        for (int k = 0; k < 40 && m_cur != t; k++) pulse(0, 0, 1, 0, 0);
        chk("goto_bound", 64'(m_cur), 64'(t));
    endtask

    task automatic pick(input int t);
        goto(t);
        pulse(1, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) pulse(0, 0, 0, 1, 0);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [NC*SYMW-1:0] deck_a, deck_b;

    initial begin
        for (int i = 0; i < NC; i++) begin
            deck_a[i*SYMW +: SYMW] = SYMW'(i / 2);
            deck_b[i*SYMW +: SYMW] = SYMW'(i % 8);
        end
        bus.start = 0; bus.tick = 0; bus.left = 0; bus.right = 0; bus.sel = 0;
        bus.deck_sym = deck_a;

        // Reset values
        rst = 1;
        cyc(2);
        chk("rst_secs", 64'(bus.secs_left), 64'd15);
        chk("rst_card_st", 64'(bus.card_st), 64'd0);
        chk("rst_over", 64'(bus.game_over), 64'd0);
        @(negedge clk);
        rst = 0;

        // 1: first pair matched by player 0
        pulse(0, 0, 0, 0, 1);
        chk("t1_sym2", 64'(bus.card_sym[2*SYMW +: SYMW]), 64'd1);
        pick(0);
        pick(1);
        cyc(2);
        chk("t1_st01", 64'(bus.card_st[3:0]), 64'b1010);
        chk("t1_score0", 64'(bus.scores[1:0]), 64'd1);
        chk("t1_turn", 64'(bus.turn), 64'd0);
        bus.deck_sym = deck_b;
        pulse(0, 0, 0, 0, 1);
        chk("t1_start_ignored", 64'(bus.card_sym[2*SYMW +: SYMW]), 64'd1);

        // 2: mismatch, reveal holds for two ticks, then next player
        pick(2);
        pick(4);
        cyc(2);
        pulse(0, 0, 1, 0, 0);
        chk("t2_cursor_frozen", 64'(bus.cursor), 64'd4);
        ticks(1);
        chk("t2_still_shown", 64'(bus.card_st[9:8]), 64'd1);
        ticks(1);
        cyc(1);
        chk("t2_hidden", 64'(bus.card_st[9:4]), 64'd0);
        chk("t2_turn", 64'(bus.turn), 64'd1);
        chk("t2_secs", 64'(bus.secs_left), 64'd15);

        // 3: timeout after first pick, cursor wrap
        pick(4);
        ticks(3);
        chk("t3_secs12", 64'(bus.secs_left), 64'd12);
        ticks(11);
        chk("t3_secs1", 64'(bus.secs_left), 64'd1);
        ticks(1);
        chk("t3_a_hidden", 64'(bus.card_st[9:8]), 64'd0);
        chk("t3_turn", 64'(bus.turn), 64'd2);
        for (int k = 0; k < 5; k++) pulse(0, 1, 0, 0, 0);
        chk("t3_wrap_left", 64'(bus.cursor), 64'd15);
        pulse(0, 1, 1, 0, 0);
        chk("t3_both_dirs", 64'(bus.cursor), 64'd15);

        // Timeout from first pick with a simultaneous sel
        ticks(14);
        pulse(1, 0, 0, 1, 0);
        chk("t3_sel_dropped", 64'(bus.card_st[31:30]), 64'd0);
        chk("t3_timeout_turn", 64'(bus.turn), 64'd0);
        chk("t3_timeout_secs", 64'(bus.secs_left), 64'd15);

        // 4: three mismatches rotate through all three players
        for (int r = 0; r < 3; r++) begin
            pick(2);
            pick(4);
            cyc(2);
            ticks(2);
            chk("t4_turn", 64'(bus.turn), 64'((r + 1) % 3));
        end
        pick(0);
        chk("t4_matched_kept", 64'(bus.card_st[1:0]), 64'd2);
        pick(2);
        pulse(1, 0, 0, 0, 0);
        chk("t4_shown_kept", 64'(bus.card_st[5:4]), 64'd1);
        pick(3);
        cyc(2);
        chk("t4_score0", 64'(bus.scores[1:0]), 64'd2);

        // 6: reset in reveal, then new deck
        pick(4);
        pick(6);
        cyc(2);
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("t6_card_st", 64'(bus.card_st), 64'd0);
        chk("t6_card_sym", 64'(bus.card_sym), 64'd0);
        chk("t6_scores", 64'(bus.scores), 64'd0);
        chk("t6_cursor", 64'(bus.cursor), 64'd0);
        chk("t6_turn", 64'(bus.turn), 64'd0);
        chk("t6_secs", 64'(bus.secs_left), 64'd15);
        chk("t6_winner", 64'(bus.winner), 64'd0);
        @(negedge clk);
        rst = 0;
        bus.deck_sym = deck_b;
        pulse(0, 0, 0, 0, 1);
        chk("t6_new_deck", 64'(bus.card_sym[9*SYMW +: SYMW]), 64'd1);

        // 5: player 0 clears the board (score saturates at 3)
        for (int p = 0; p < 8; p++) begin
            pick(p);
            pick(p + 8);
            cyc(2);
        end
        chk("t5_over", 64'(bus.game_over), 64'd1);
        chk("t5_winner", 64'(bus.winner), 64'd0);
        chk("t5_scores", 64'(bus.scores), 64'h03);
        pulse(0, 1, 0, 0, 0);

        // Restart from game over, then a tied game
        pulse(0, 0, 0, 0, 1);
        chk("t5_restart_over", 64'(bus.game_over), 64'd0);
        chk("t5_restart_scores", 64'(bus.scores), 64'd0);
        for (int p = 0; p < 4; p++) begin
            pick(p);
            pick(p + 8);
            cyc(2);
        end
        pick(4);
        pick(5);
        cyc(2);
        ticks(2);
        chk("t5_turn1", 64'(bus.turn), 64'd1);
        for (int p = 4; p < 8; p++) begin
            pick(p);
            pick(p + 8);
            cyc(2);
        end
        chk("t5_tie_over", 64'(bus.game_over), 64'd1);
        chk("t5_tie_winner", 64'(bus.winner), 64'b100);
        chk("t5_tie_scores", 64'(bus.scores), 64'h0f);
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
